// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader: read-side master for the byte FIFO. Packs bytes
// little-endian into OUT_BYTES-wide words on a valid/ready stream and
// supports a flush that emits a zero-padded partial word.
module fifo_byte_reader #(
  parameter int RD_LATENCY = 1,
  parameter int OUT_BYTES  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  output logic                   rd_en,
  input  logic [7:0]             data_out,
  input  logic                   flush,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [8*OUT_BYTES-1:0] word_data,
  output logic [3:0]             word_nbytes,
  output logic                   flush_done,
  output logic [CNT_W-1:0]       rd_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_EMIT} state_t;

  state_t                        r_state, w_state_nxt;
  logic [RD_LATENCY-1:0]         r_vld_pipe;
  logic [OUT_BYTES-1:0][7:0]     r_asm;
  logic [3:0]                    r_held;
  logic                          r_word_valid;
  logic [OUT_BYTES-1:0][7:0]     r_word_data;
  logic [3:0]                    r_word_nbytes;
  logic                          r_flush_done;
  logic [CNT_W-1:0]              r_rd_count;

  logic                          w_tap, w_out_free, w_full, w_move, w_emit;
  logic                          w_room, w_done_nxt;
  logic [3:0]                    w_inflight, w_held_base, w_held_nxt;
  logic [4:0]                    w_sum;
  logic [OUT_BYTES-1:0][7:0]     w_part;

  assign w_tap      = r_vld_pipe[RD_LATENCY-1];
  assign w_out_free = !r_word_valid || word_ready;
  assign w_full     = (r_held == 4'(OUT_BYTES));
  assign w_move     = w_full && w_out_free;
  assign w_emit     = (r_state == S_EMIT) && w_out_free;
  assign w_sum      = 5'(r_held) + 5'(w_inflight);

  // Count reads still in flight (ones in the latency shift)
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + 4'(r_vld_pipe[i]);
  end

  // Room check. The last term lets a read start when it exactly fills the
  // assembler while the output register is empty: nothing but this
  // assembler can fill the output, so it is still free when the word
  // completes, and the arriving byte lands in slot 0 of the next word.
  // That closes the one-cycle bubble at each word boundary.
  always_comb begin
    w_room = (w_sum < 5'(OUT_BYTES))
          || (w_full && w_out_free && (w_inflight < 4'(OUT_BYTES)))
          || ((w_sum == 5'(OUT_BYTES)) && !r_word_valid);
  end

  assign rd_en = enable && !fifo_empty && (r_state == S_RUN) && !flush && w_room;

  // Held count after this cycle's word move / emit, then plus the arriving byte
  always_comb begin
    w_held_base = (w_move || w_emit) ? 4'd0 : r_held;
    w_held_nxt  = w_held_base + 4'(w_tap);
  end

  // Partial word: held bytes, upper bytes forced to zero
  always_comb begin
    for (int i = 0; i < OUT_BYTES; i++)
      w_part[i] = (4'(i) < r_held) ? r_asm[i] : 8'h00;
  end

  // Flush FSM next-state and completion pulse
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_RUN:   if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_inflight == 4'd0) begin
          if (w_held_base == 4'd0) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (w_out_free) begin
          w_state_nxt = S_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State, flush pulse, in-flight shift and byte counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_RUN;
      r_flush_done <= 1'b0;
      r_vld_pipe   <= '0;
      r_rd_count   <= '0;
      r_held       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_done  <= w_done_nxt;
      r_vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      r_rd_count    <= r_rd_count + CNT_W'(w_tap);
      r_held        <= w_held_nxt;
    end
  end

  // Assembler: arriving byte goes to the slot after the surviving held bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_asm <= '0;
    end else begin
      for (int i = 0; i < OUT_BYTES; i++)
        if (w_tap && (w_held_base == 4'(i))) r_asm[i] <= data_out;
    end
  end

  // Output register: full-word move, flush emit, or drop valid on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_valid  <= 1'b0;
      r_word_data   <= '0;
      r_word_nbytes <= '0;
    end else if (w_move) begin
      r_word_valid  <= 1'b1;
      r_word_data   <= r_asm;
      r_word_nbytes <= 4'(OUT_BYTES);
    end else if (w_emit) begin
      r_word_valid  <= 1'b1;
      r_word_data   <= w_part;
      r_word_nbytes <= r_held;
    end else if (word_ready) begin
      r_word_valid  <= 1'b0;
    end
  end

  assign word_valid  = r_word_valid;
  assign word_data   = r_word_data;
  assign word_nbytes = r_word_nbytes;
  assign flush_done  = r_flush_done;
  assign rd_count    = r_rd_count;

endmodule
